// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch engine.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W  = 32;
    localparam int unsigned INST_W       = 32;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned IF_STALL_BIT = 1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_VALID   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Payload handed to the IF/ID pipeline register.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } if_word_t;

endpackage

// File: rtl/if_fetch.sv
// IF-stage fetch engine: owns the PC, runs the ibus req/ack handshake and
// presents {if_pc, if_inst}; handles flush redirects and delay-slot branches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic                   ibus_req_o,
    output logic [INST_ADDR_W-1:0] ibus_addr_o,
    input  logic [INST_W-1:0]      ibus_data_i,
    input  logic                   ibus_ack_i,
    output logic                   stallreq_o,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   req_q, req_d;
    logic [INST_ADDR_W-1:0] addr_q, addr_d;
    if_word_t               word_q, word_d;
    logic                   redir_valid_q, redir_valid_d;
    logic [INST_ADDR_W-1:0] redir_pc_q, redir_pc_d;

    logic                   ack;
    logic                   consume;
    logic [INST_ADDR_W-1:0] next_pc;

    // Only the IF bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:IF_STALL_BIT+1], stall[IF_STALL_BIT-1:0]};

    assign ack     = ibus_ack_i & req_q;
    assign consume = (stall[IF_STALL_BIT] == NO_STOP);

    // A branch seen while the delay slot is being consumed wins over a stored redirect.
    always_comb begin
        if (branch_flag_i) begin
            next_pc = branch_target_address_i;
        end else if (redir_valid_q) begin
            next_pc = redir_pc_q;
        end else begin
            next_pc = INST_ADDR_W'(pc_q + INST_ADDR_W'(4));
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_d         = req_q;
        addr_d        = addr_q;
        word_d        = word_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;

        if (flush) begin
            redir_valid_d = 1'b0;
            pc_d          = new_pc;
            if ((state_q == ST_FETCH || state_q == ST_DISCARD) && !ack) begin
                // Request still in flight: keep req/addr stable and drop its data later.
                state_d = ST_DISCARD;
            end else begin
                state_d     = ST_FETCH;
                req_d       = 1'b1;
                addr_d      = new_pc;
                word_d.pc   = ZERO_WORD;
                word_d.inst = ZERO_WORD;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (branch_flag_i) begin
                        redir_valid_d = 1'b1;
                        redir_pc_d    = branch_target_address_i;
                    end
                    if (ack) begin
                        state_d     = ST_VALID;
                        req_d       = 1'b0;
                        word_d.pc   = pc_q;
                        word_d.inst = ibus_data_i;
                    end
                end
                ST_VALID: begin
                    if (consume) begin
                        state_d       = ST_FETCH;
                        pc_d          = next_pc;
                        addr_d        = next_pc;
                        req_d         = 1'b1;
                        redir_valid_d = 1'b0;
                        word_d.pc     = ZERO_WORD;
                        word_d.inst   = ZERO_WORD;
                    end else if (branch_flag_i) begin
                        redir_valid_d = 1'b1;
                        redir_pc_d    = branch_target_address_i;
                    end
                end
                ST_DISCARD: begin
                    if (ack) begin
                        state_d = ST_FETCH;
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_FETCH;
                    addr_d      = pc_q;
                    req_d       = 1'b1;
                    word_d.pc   = ZERO_WORD;
                    word_d.inst = ZERO_WORD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            req_q         <= 1'b1;
            addr_q        <= RESET_PC;
            word_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign ibus_req_o  = req_q;
    assign ibus_addr_o = addr_q;
    assign stallreq_o  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign if_pc       = word_q.pc;
    assign if_inst     = word_q.inst;

endmodule
